des_decrypt: RTL and testbench
==============================

DES_DECRYPT -- requirements
Module: des_decrypt

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  level request; sampled only in IDLE and DONE.
REQ-004 ciphertext  input  64  DES block; bit 63 = DES bit 1.
REQ-005 key  input  64  DES key with parity bits; parity bits are ignored.
REQ-006 plaintext_out  output  64  registered result; valid while done=1.
REQ-007 done  output  1  registered; high while the FSM is in DONE.
REQ-008 busy  output  1  registered; high while the FSM is in ROUND.

Function
REQ-009 Algorithm SHALL be standard DES decryption: IP, 16 Feistel rounds using subkeys K16..K1 in that order, swap to (R16,L16), then FP.
REQ-010 FSM states SHALL be IDLE, ROUND and DONE, with a 4-bit round counter rnd (values 0..15).
REQ-011 In IDLE with start=1, one edge SHALL latch IP(ciphertext) into L/R and PC1(key) into C/D, set rnd=0, set busy=1, and go to ROUND.
REQ-012 ciphertext and key SHALL be sampled only at that edge; later input changes do not affect the running operation.
REQ-013 Each ROUND edge SHALL compute L<=R and R<=L^f(R,K(16-rnd)), then increment rnd.
REQ-014 At the edge where rnd=15, the FSM SHALL also set plaintext_out<=FP({R_new,L_new}), done<=1, busy<=0, and go to DONE.
REQ-015 Latency SHALL be 16 edges from the start-sampling edge to done=1, i.e. 17 clock edges in total including the start edge.
REQ-016 DONE SHALL hold plaintext_out and done while start=1.
REQ-017 In DONE with start=0, one edge SHALL return the FSM to IDLE with done<=0; plaintext_out keeps its last value.
REQ-018 start=1 during ROUND SHALL be ignored; no restart and no input resampling occur.
REQ-019 A new operation requires start to fall then rise again; back-to-back ops therefore take at least 18 edges each.
REQ-020 busy and done SHALL never be high simultaneously.
REQ-021 Invalid state encodings SHALL go to IDLE on the next edge.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, rnd=0, L=R=0, C=D=0, plaintext_out=0, done=0 and busy=0, including mid-operation.
REQ-023 After rst falls, the block SHALL start an operation only on a fresh start sample in IDLE; the aborted operation is never completed.

Configuration
REQ-024 With macro DES_DEC_ITER_KEY_EN defined, the subkey SHALL come from the C/D registers: initial C/D=PC1(key) yields K16=PC2(C,D).
REQ-025 In that mode, after the round using Ki, C and D SHALL each rotate right by shift(i), where shift(i)=1 for i in {1,2,9,16} and 2 otherwise.
REQ-026 Without the macro, all 16 subkeys SHALL be derived combinationally from the latched key with left rotations, and a mux SHALL select K(16-rnd).
REQ-027 Outputs and cycle timing SHALL be identical in both builds.

Structure
REQ-028 Package des_pkg SHALL hold the FSM state encodings, the round count (16) and the shift(i) schedule function.
REQ-029 The block SHALL reuse the existing permutation and round-function modules: des_ip_stage, pc1_perm, pc2_perm, f_func and fp_perm.
REQ-030 One sub-module, des_dec_keysched, SHALL contain the C/D registers and rotation logic and present the current 48-bit subkey for both builds.

Verification
REQ-031 key=133457799BBCDFF1, ciphertext=85E813540F0AB405, start=1 -> plaintext_out=0123456789ABCDEF, with done rising exactly 16 edges after the start edge.
REQ-032 key=0E329232EA6D0D73, ciphertext=0000000000000000 -> plaintext_out=8787878787878787; busy=1 for exactly 16 cycles.
REQ-033 Change ciphertext and key every cycle during ROUND and hold start=1 throughout -> the result matches the first sampled inputs, and done stays high until start=0.
REQ-034 Assert rst during round 8 -> all outputs become 0 immediately; a subsequent start produces the correct REQ-031 result.
REQ-035 Run REQ-031 and REQ-032 back-to-back with start low for one cycle between them -> both results are correct, and busy/done are never both 1.
REQ-036 Run the full bench with and without DES_DEC_ITER_KEY_EN, and run encrypt-then-decrypt on random vectors -> traces are identical and decryption recovers the original plaintext.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared FSM encodings, round count and key-shift schedule for des_decrypt
package des_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KS_HOLD = 2'd0,
    KS_LOAD = 2'd1,
    KS_STEP = 2'd2
  } ks_op_t;

  // Rotation applied to C/D for subkey i (1-based).
  function automatic int key_shift(input int i);
    return (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
  endfunction

  function automatic int cum_shift(input int i);
    int total;
    total = 0;
    for (int j = 1; j <= i; j++) total += key_shift(j);
    return total;
  endfunction

endpackage

// File: rtl/des_decrypt_if.sv
// rtl/des_decrypt_if.sv - request/result bundle between a requester and des_decrypt
interface des_decrypt_if;
  logic        start;
  logic [63:0] ciphertext;
  logic [63:0] key;
  logic [63:0] plaintext_out;
  logic        done;
  logic        busy;

  modport master (output start, ciphertext, key, input plaintext_out, done, busy);
  modport slave  (input start, ciphertext, key, output plaintext_out, done, busy);
endinterface

// File: rtl/des_dec_keysched.sv
// rtl/des_dec_keysched.sv - C/D key registers and current decryption subkey
// DES_DEC_ITER_KEY_EN: rotate C/D right each round; otherwise mux 16 combinational subkeys.
module des_dec_keysched import des_pkg::*; (
  input  logic        clock,
  input  logic        rst,
  input  ks_op_t      op,
  input  logic [63:0] key,
  input  logic [3:0]  rnd,
  output logic [47:0] subkey
);
  logic [55:0] pc1_out;
  logic [27:0] c, d;

  pc1_perm u_pc1 (.data(key), .result(pc1_out));

`ifdef DES_DEC_ITER_KEY_EN
  // C16/D16 equal C0/D0, so the loaded value already yields K16.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      c <= '0;
      d <= '0;
    end else if (op == KS_LOAD) begin
      c <= pc1_out[55:28];
      d <= pc1_out[27:0];
    end else if (op == KS_STEP) begin
      if (key_shift(ROUNDS - int'(rnd)) == 1) begin
        c <= {c[0], c[27:1]};
        d <= {d[0], d[27:1]};
      end else begin
        c <= {c[1:0], c[27:2]};
        d <= {d[1:0], d[27:2]};
      end
    end
  end

  pc2_perm u_pc2 (.data({c, d}), .result(subkey));
`else
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      c <= '0;
      d <= '0;
    end else if (op == KS_LOAD) begin
      c <= pc1_out[55:28];
      d <= pc1_out[27:0];
    end
  end

  // keys[j] holds K(16-j), so rnd indexes it directly.
  logic [47:0] keys [16];
  for (genvar j = 0; j < 16; j++) begin : g_sub
    localparam int SH = cum_shift(ROUNDS - j);
    logic [27:0] cr, dr;
    assign cr = (c << SH) | (c >> (28 - SH));
    assign dr = (d << SH) | (d >> (28 - SH));
    pc2_perm u_pc2 (.data({cr, dr}), .result(keys[j]));
  end

  assign subkey = keys[rnd];
`endif
endmodule

// File: rtl/des_prims.sv
// rtl/des_prims.sv - DES permutation and round-function primitives (bit 63 = DES bit 1)
module des_ip_stage (
  input  logic [63:0] data,
  output logic [63:0] result
);
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  always_comb begin
    result = '0;
    for (int i = 0; i < 64; i++) result[63-i] = data[64-IP_T[i]];
  end
endmodule

module fp_perm (
  input  logic [63:0] data,
  output logic [63:0] result
);
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  always_comb begin
    result = '0;
    for (int i = 0; i < 64; i++) result[63-i] = data[64-FP_T[i]];
  end
endmodule

module pc1_perm (
  input  logic [63:0] data,
  output logic [55:0] result
);
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  // Key parity bits never reach the schedule.
  logic unused_parity;
  assign unused_parity = ^{data[56], data[48], data[40], data[32],
                           data[24], data[16], data[8], data[0]};

  always_comb begin
    result = '0;
    for (int i = 0; i < 56; i++) result[55-i] = data[64-PC1_T[i]];
  end
endmodule

module pc2_perm (
  input  logic [55:0] data,
  output logic [47:0] result
);
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic unused_dropped;
  assign unused_dropped = ^{data[47], data[38], data[34], data[31],
                            data[21], data[18], data[13], data[2]};

  always_comb begin
    result = '0;
    for (int i = 0; i < 48; i++) result[47-i] = data[56-PC2_T[i]];
  end
endmodule

module f_func (
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] result
);
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // Each S-box is 64 nibbles, row-major, entry 0 in the top nibble.
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [47:0] x;
  logic [31:0] s_out;
  logic [5:0]  six;
  int          idx;

  always_comb begin
    x = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ subkey;
    s_out = '0;
    six = '0;
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      idx = int'({six[5], six[0], six[4:1]});
      s_out[31-4*s -: 4] = SB[s][255-4*idx -: 4];
    end
    result = '0;
    for (int i = 0; i < 32; i++) result[31-i] = s_out[32-P_T[i]];
  end
endmodule

// File: rtl/des_decrypt.sv
// rtl/des_decrypt.sv - iterative DES decryptor, one Feistel round per clock
// Key schedule style selected by DES_DEC_ITER_KEY_EN inside des_dec_keysched.
module des_decrypt import des_pkg::*; (
  input  logic         clock,
  input  logic         rst,
  des_decrypt_if.slave bus
);
  state_t      state;
  logic [3:0]  rnd;
  logic [31:0] l, r;
  logic [31:0] r_new, f_out;
  logic [63:0] ip_out, fp_out;
  logic [47:0] subkey;
  ks_op_t      op;

  always_comb begin
    op = KS_HOLD;
    if (state == IDLE && bus.start) op = KS_LOAD;
    else if (state == ROUND)        op = KS_STEP;
  end

  des_ip_stage u_ip (.data(bus.ciphertext), .result(ip_out));

  des_dec_keysched u_ks (
    .clock  (clock),
    .rst    (rst),
    .op     (op),
    .key    (bus.key),
    .rnd    (rnd),
    .subkey (subkey)
  );

  f_func u_f (.r(r), .subkey(subkey), .result(f_out));

  assign r_new = l ^ f_out;

  // Final swap: {R16, L16} where L16 is the current R.
  fp_perm u_fp (.data({r_new, r}), .result(fp_out));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rnd               <= '0;
      l                 <= '0;
      r                 <= '0;
      bus.plaintext_out <= '0;
      bus.done          <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            l        <= ip_out[63:32];
            r        <= ip_out[31:0];
            rnd      <= '0;
            bus.busy <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          l   <= r;
          r   <= r_new;
          rnd <= rnd + 4'd1;
          if (rnd == 4'(ROUNDS - 1)) begin
            bus.plaintext_out <= fp_out;
            bus.done          <= 1'b1;
            bus.busy          <= 1'b0;
            state             <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          rnd      <= '0;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt.sv
// tb/tb_des_decrypt.sv - scoreboard bench for des_decrypt with a reference DES encryptor
module tb_des_decrypt;
  logic clock = 1'b0;
  logic rst   = 1'b1;

  des_decrypt_if bus ();

  des_decrypt dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;
  int quiet    = 0;
  logic done_seen = 1'b0;
  logic [63:0] sb[$];
  logic [63:0] pt_r, k_r;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT2  = 64'h0000000000000000;
  localparam logic [63:0] PT2  = 64'h8787878787878787;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] do_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  // Final permutation taken as the inverse of IP.
  function automatic logic [63:0] do_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] x;
    logic [31:0] s_out, y;
    logic [5:0]  six;
    int          idx;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ sk;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      idx = int'({six[5], six[0], six[4:1]});
      s_out[31-4*s -: 4] = SB[s][255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s_out[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_encrypt(input logic [63:0] pt, input logic [63:0] k);
    logic [55:0] cd, cdr;
    logic [47:0] sk;
    logic [27:0] c, d;
    logic [63:0] blk;
    logic [31:0] l, r, t;
    int          s;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    blk = do_ip(pt);
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 1; i <= 16; i++) begin
      s = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      c = (c << s) | (c >> (28 - s));
      d = (d << s) | (d >> (28 - s));
      cdr = {c, d};
      for (int b = 0; b < 48; b++) sk[47-b] = cdr[56-PC2_T[b]];
      t = r;
      r = l ^ feistel(r, sk);
      l = t;
    end
    return do_fp({r, l});
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every rising done pops one expected plaintext.
  always @(negedge clock) begin
    if (bus.busy && bus.done) overlap <= overlap + 1;
    if (bus.done && !done_seen) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("plaintext", bus.plaintext_out, sb.pop_front());
    end
    done_seen <= bus.done;
  end

  task automatic run_op(input logic [63:0] ct, input logic [63:0] k, input logic [63:0] exp,
                        input bit scramble, input int hold);
    int edges;
    int busy_cycles;
    bus.ciphertext = ct;
    bus.key        = k;
    bus.start      = 1'b1;
    sb.push_back(exp);
    edges       = 0;
    busy_cycles = 0;
    while (!bus.done && edges < 40) begin
      @(negedge clock);
      edges++;
      if (bus.busy) busy_cycles++;
      if (scramble) begin
        bus.ciphertext = {$urandom, $urandom};
        bus.key        = {$urandom, $urandom};
      end
    end
    check("latency", 64'(edges - 1), 64'd16);
    check("busy_cycles", 64'(busy_cycles), 64'd16);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("done_hold", {63'd0, bus.done}, 64'd1);
      check("pt_hold", bus.plaintext_out, exp);
    end
    bus.start = 1'b0;
    @(negedge clock);
    check("done_clear", {63'd0, bus.done}, 64'd0);
    check("pt_keep", bus.plaintext_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.ciphertext = '0;
    bus.key        = '0;
    repeat (2) @(negedge clock);
    check("rst_pt", bus.plaintext_out, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0;
    @(negedge clock);

    run_op(CT1, KEY1, PT1, 1'b0, 3);
    run_op(CT2, KEY2, PT2, 1'b0, 0);
    run_op(CT1, KEY1, PT1, 1'b1, 5);

    // Abort in round 8, then confirm the aborted operation never completes.
    bus.ciphertext = CT2;
    bus.key        = KEY2;
    bus.start      = 1'b1;
    sb.push_back(PT2);
    repeat (9) @(negedge clock);
    check("mid_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_pt", bus.plaintext_out, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    sb.delete();
    bus.start = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    repeat (24) begin
      @(negedge clock);
      if (bus.busy || bus.done) quiet++;
    end
    check("abort_quiet", 64'(quiet), 64'd0);

    run_op(CT1, KEY1, PT1, 1'b0, 1);

    for (int v = 0; v < 6; v++) begin
      pt_r = {$urandom, $urandom};
      k_r  = {$urandom, $urandom};
      run_op(des_encrypt(pt_r, k_r), k_r, pt_r, v[0], v % 3);
    end

    check("busy_done_overlap", 64'(overlap), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
